split_eval_sequencer: RTL

//  Feeds one flat constraint-check datapath (combinational split_* evaluator, VEC_W-bit packed assignment in, 1-bit sat out).

---
 rtl/split_eval_pkg.sv | 21 ++
 rtl/split_chunk_assembler.sv | 74 +++++++
 rtl/split_eval_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/split_eval_pkg.sv
// Shared types and sizing helpers for the split_eval_sequencer block.
package split_eval_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Wait counter width; EVAL_LAT is legal 0..15.
  localparam int LAT_W = 4;

  function automatic int num_chunks(input int vec_w, input int chunk_w);
    return (vec_w + chunk_w - 1) / chunk_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_chunk_assembler.sv
// Chunk index counter, chunk write / zero-fill into the assembled vector and
// in_last framing check for split_eval_sequencer.
module split_chunk_assembler
  import split_eval_pkg::*;
#(
  parameter int VEC_W   = 516,
  parameter int CHUNK_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  input  logic               err_clr,
  output logic [VEC_W-1:0]   vec_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int NUM_CHUNKS = num_chunks(VEC_W, CHUNK_W);
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             err_q, err_d;
  logic [PAD_W-1:0] vec_pad;
  logic             is_final;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    is_final = (idx_q == LAST_IDX);
    done_o   = wr_en & (is_final | in_last);
    idx_d    = idx_q;
    err_d    = err_q;
    vec_pad  = PAD_W'(vec_q);

    if (wr_en) idx_d = (is_final | in_last) ? '0 : idx_q + IDX_W'(1);

    if (err_clr) err_d = 1'b0;
    // Framing error: in_last early, or missing on the final chunk.
    if (wr_en & (in_last ^ is_final)) err_d = 1'b1;

    // The padded copy lets the final chunk be written whole; bits above VEC_W are dropped below.
    if (wr_en) begin
      for (int j = 0; j < NUM_CHUNKS; j++) begin
        if (IDX_W'(j) == idx_q)
          vec_pad[j*CHUNK_W +: CHUNK_W] = in_data;
        else if (in_last && (IDX_W'(j) > idx_q))
          vec_pad[j*CHUNK_W +: CHUNK_W] = '0;
      end
    end
    vec_d = vec_pad[VEC_W-1:0];
  end

  // NOTE: vec_q is a wide register bank, not a RAM, so it takes the async reset; a true memory array would not.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      vec_q <= '0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      vec_q <= vec_d;
      err_q <= err_d;
    end
  end

  assign vec_o = vec_q;
  assign err_o = err_q;

endmodule

// File: rtl/split_eval_sequencer.sv
// Assembles a packed assignment from a chunk stream, runs one evaluation window
// and returns sat/err over valid/ready. Optional counters: SPLIT_EVAL_STATS_EN.
module split_eval_sequencer
  import split_eval_pkg::*;
#(
  parameter int VEC_W    = 516,
  parameter int CHUNK_W  = 32,
  parameter int EVAL_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic [VEC_W-1:0]   vec_o,
  output logic               eval_start,
  input  logic               sat_i,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_sat,
  output logic               res_err,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   cnt_total,
  output logic [CNT_W-1:0]   cnt_sat
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             in_ready_q, in_ready_d;
  logic             eval_start_q, eval_start_d;
  logic             res_valid_q, res_valid_d;
  logic             res_sat_q, res_sat_d;
  logic             accept, done, res_hs;

  assign accept = in_valid & in_ready_q;
  assign res_hs = res_valid_q & res_ready;

  split_chunk_assembler #(
    .VEC_W   (VEC_W),
    .CHUNK_W (CHUNK_W)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .in_data (in_data),
    .in_last (in_last),
    .err_clr (res_hs),
    .vec_o   (vec_o),
    .done_o  (done),
    .err_o   (res_err)
  );

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    in_ready_d   = in_ready_q;
    eval_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_sat_d    = res_sat_q;
    unique case (state_q)
      ST_LOAD: if (done) begin
        state_d      = ST_EVAL;
        lat_d        = LAT_W'(EVAL_LAT);
        eval_start_d = 1'b1;
        in_ready_d   = 1'b0;
      end
      // With EVAL_LAT=0 sat_i is sampled in the same cycle eval_start is high.
      ST_EVAL: if (lat_q == '0) begin
        state_d     = ST_RESP;
        res_sat_d   = sat_i;
        res_valid_d = 1'b1;
      end else begin
        lat_d = lat_q - LAT_W'(1);
      end
      ST_RESP: if (res_ready) begin
        state_d     = ST_LOAD;
        res_valid_d = 1'b0;
        res_sat_d   = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: begin
        state_d     = ST_LOAD;
        in_ready_d  = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      lat_q        <= '0;
      in_ready_q   <= 1'b1;
      eval_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      in_ready_q   <= in_ready_d;
      eval_start_q <= eval_start_d;
      res_valid_q  <= res_valid_d;
      res_sat_q    <= res_sat_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign eval_start = eval_start_q;
  assign res_valid  = res_valid_q;
  assign res_sat    = res_sat_q;

`ifdef SPLIT_EVAL_STATS_EN
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_sat_q, cnt_sat_d;

  // Saturating counters; a clear beats a same-cycle increment.
  always_comb begin
    cnt_total_d = cnt_total_q;
    cnt_sat_d   = cnt_sat_q;
    if (stats_clr) begin
      cnt_total_d = '0;
      cnt_sat_d   = '0;
    end else if (res_hs) begin
      if (cnt_total_q != '1) cnt_total_d = cnt_total_q + CNT_W'(1);
      if (res_sat_q && (cnt_sat_q != '1)) cnt_sat_d = cnt_sat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total_q <= '0;
      cnt_sat_q   <= '0;
    end else begin
      cnt_total_q <= cnt_total_d;
      cnt_sat_q   <= cnt_sat_d;
    end
  end

  assign cnt_total = cnt_total_q;
  assign cnt_sat   = cnt_sat_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign cnt_total        = '0;
  assign cnt_sat          = '0;
`endif

endmodule
